// File: rtl/sr_drive_ctrl_pkg.sv
// Shared definitions for the S/R flip-flop drive controller: FSM state
// encoding, commanded-target constants and a small constant helper.
package sr_drive_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic TGT_SET = 1'b1;
  localparam logic TGT_RST = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_drive_ctrl_debounce_sync.sv
// One request channel: 2-flop synchronizer, debounce counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module debounce_sync #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise
);

  localparam int            CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  // Stage p0/p1: bring the raw asynchronous input into the CLK domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge pulse of the debounced level; falling edges ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Clean S/R command generator for an external sr_ff: debounces two raw
// request lines, arbitrates them, issues one spaced pulse per command and
// verifies the flip-flop output after each command.
module sr_drive_ctrl
  import sr_drive_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 1,
  parameter int GUARD_LEN  = 2,
  parameter int PRIO_SET   = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_IN,
  input  logic RST_IN,
  input  logic Q_FB,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT,
  output logic FAULT
);

  localparam int              PH_W       = $clog2(max_int(PULSE_LEN, GUARD_LEN)) + 1;
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_LEN - 1);
  localparam logic [PH_W-1:0] GUARD_LAST = PH_W'(GUARD_LEN - 1);

  // Phase counter saturates at all-ones rather than wrapping.
  function automatic logic [PH_W-1:0] sat_inc(input logic [PH_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic            set_rise;
  logic            rst_rise;
  logic            pend_s;
  logic            pend_r;
  logic            idle_go;
  logic            take_set;
  state_t          state;
  logic            tgt;
  logic [PH_W-1:0] ph;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .CLK  (CLK),
    .RST  (RST),
    .din  (SET_IN),
    .rise (set_rise)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .CLK  (CLK),
    .RST  (RST),
    .din  (RST_IN),
    .rise (rst_rise)
  );

  // IDLE takes whatever is pending; on a tie the priority rule picks the target.
  assign idle_go  = (state == IDLE) && (pend_s || pend_r);
  assign take_set = pend_s & ((PRIO_SET != 0) | ~pend_r);

  // Busy also covers the cycle a pending request waits for IDLE to take it,
  // so the flag stays high from request commit to the end of CHECK.
  assign BUSY = (state != IDLE) | pend_s | pend_r;

  // One-deep pending flags: new edges merge, acceptance clears both (loser dropped).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_s <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      pend_s <= set_rise | (pend_s & ~idle_go);
      pend_r <= rst_rise | (pend_r & ~idle_go);
    end
  end

  // Command FSM with registered S/R/CONFLICT/FAULT; S and R are never set together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tgt      <= TGT_RST;
      ph       <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      CONFLICT <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      CONFLICT <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_go) begin
            tgt      <= take_set ? TGT_SET : TGT_RST;
            S        <= take_set;
            R        <= ~take_set;
            CONFLICT <= pend_s & pend_r;
            ph       <= '0;
            state    <= PULSE;
          end
        end
        PULSE: begin
          if (ph == PULSE_LAST) begin
            S     <= 1'b0;
            R     <= 1'b0;
            ph    <= '0;
            state <= GUARD;
          end else begin
            ph <= sat_inc(ph);
          end
        end
        GUARD: begin
          if (ph == GUARD_LAST) begin
            ph    <= '0;
            state <= CHECK;
          end else begin
            ph <= sat_inc(ph);
          end
        end
        CHECK: begin
          if (Q_FB != tgt) FAULT <= 1'b1;
          state <= IDLE;
        end
        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: expected pulse starts are queued when a request is
// driven and popped when the controller starts a pulse; a behavioural sr_ff
// closes the Q_FB loop. A second instance with PULSE_LEN=3 covers async reset.
module tb_sr_drive_ctrl;

  localparam int DEB = 4;
  localparam int PL  = 1;
  localparam int GL  = 2;
  localparam int LAT = DEB + 5;  // negedge of drive -> negedge where S is first seen high

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst, set_in, rst_in, q_fb = 1'b0, q_tie0;
  logic s, r, busy, conflict, fault;
  logic rst3, set3, rst_in3, q3 = 1'b0;
  logic s3, r3, busy3, conflict3, fault3;

  sr_drive_ctrl #(.DEB_CYCLES(DEB), .PULSE_LEN(PL), .GUARD_LEN(GL), .PRIO_SET(1)) dut (
    .CLK(CLK), .RST(rst), .SET_IN(set_in), .RST_IN(rst_in), .Q_FB(q_fb),
    .S(s), .R(r), .BUSY(busy), .CONFLICT(conflict), .FAULT(fault)
  );

  sr_drive_ctrl #(.DEB_CYCLES(DEB), .PULSE_LEN(3), .GUARD_LEN(GL), .PRIO_SET(1)) dut3 (
    .CLK(CLK), .RST(rst3), .SET_IN(set3), .RST_IN(rst_in3), .Q_FB(q3),
    .S(s3), .R(r3), .BUSY(busy3), .CONFLICT(conflict3), .FAULT(fault3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural sr_ff models; q_tie0 forces the first one stuck at 0.
  always @(posedge CLK) begin
    if (q_tie0)  q_fb <= 1'b0;
    else if (s)  q_fb <= 1'b1;
    else if (r)  q_fb <= 1'b0;
  end
  always @(posedge CLK) begin
    if (s3)      q3 <= 1'b1;
    else if (r3) q3 <= 1'b0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    bit is_set;
    int at;
  } exp_t;
  exp_t sb[$];

  task automatic push(input bit is_set, input int at);
    exp_t e;
    e.is_set = is_set;
    e.at     = at;
    sb.push_back(e);
  endtask

  task automatic got_pulse(input bit is_set);
    exp_t e;
    if (sb.size() == 0) begin
      chk(is_set ? "unexpected_s_pulse" : "unexpected_r_pulse", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", int'(is_set), int'(e.is_set));
      chk("pulse_cycle", cyc, e.at);
    end
  endtask

  // Output monitor: pulse starts against the scoreboard, pulse widths, S/R exclusion.
  logic s_prev = 1'b0, r_prev = 1'b0;
  int   s_run = 0, r_run = 0;
  always @(negedge CLK) begin
    chk("s_and_r", int'(s & r), 0);
    chk("s3_and_r3", int'(s3 & r3), 0);
    if (s && !s_prev) got_pulse(1'b1);
    if (r && !r_prev) got_pulse(1'b0);
    if (s) s_run++;
    else if (s_run != 0) begin chk("s_width", s_run, PL); s_run = 0; end
    if (r) r_run++;
    else if (r_run != 0) begin chk("r_width", r_run, PL); r_run = 0; end
    s_prev = s;
    r_prev = r;
  end

  // One complete command on the main instance, released and settled afterwards.
  task automatic cmd(input bit is_set);
    @(negedge CLK);
    if (is_set) set_in = 1'b1; else rst_in = 1'b1;
    push(is_set, cyc + LAT);
    repeat (10) @(negedge CLK);
    set_in = 1'b0;
    rst_in = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, busy_n, conf_n, conf_at, fault_at, s3_first, s3_n;
    rst = 1'b1; set_in = 1'b0; rst_in = 1'b0; q_tie0 = 1'b0;
    rst3 = 1'b1; set3 = 1'b0; rst_in3 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_fault", fault, 0);
    chk("rst_s3", s3, 0);
    rst = 1'b0;
    rst3 = 1'b0;
    repeat (5) @(negedge CLK);

    // Clean set request held 10 cycles.
    @(negedge CLK);
    k = cyc; set_in = 1'b1; push(1'b1, k + LAT);
    busy_n = 0; conf_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 10) set_in = 1'b0;
      busy_n += int'(busy);
      conf_n += int'(conflict);
    end
    chk("clean_busy_cycles", busy_n, 5);
    chk("clean_conflict", conf_n, 0);
    chk("clean_fault", fault, 0);
    chk("clean_q", q_fb, 1);

    // Bouncing reset request, then stable high.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      rst_in = (i % 2 == 0);
    end
    @(negedge CLK);
    k = cyc; rst_in = 1'b1; push(1'b0, k + LAT);
    repeat (20) @(negedge CLK);
    rst_in = 1'b0;
    repeat (12) @(negedge CLK);
    chk("bounce_q", q_fb, 0);
    chk("bounce_queue", sb.size(), 0);

    // Simultaneous set+reset: set wins, one-cycle CONFLICT on acceptance.
    @(negedge CLK);
    k = cyc; set_in = 1'b1; rst_in = 1'b1; push(1'b1, k + LAT);
    conf_n = 0; conf_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 10) begin set_in = 1'b0; rst_in = 1'b0; end
      if (conflict) begin conf_n++; conf_at = cyc; end
    end
    chk("conflict_cycles", conf_n, 1);
    chk("conflict_at", conf_at, k + LAT);
    chk("conflict_q", q_fb, 1);

    // Reset edge lands in the set's GUARD: R follows two cycles after CHECK.
    @(negedge CLK);
    k = cyc; set_in = 1'b1; push(1'b1, k + LAT);
    repeat (2) @(negedge CLK);
    rst_in = 1'b1; push(1'b0, k + LAT + 5);
    for (int i = 1; i <= 25; i++) begin
      @(negedge CLK);
      if (i == 8) begin set_in = 1'b0; rst_in = 1'b0; end
    end
    chk("queued_fault", fault, 0);
    chk("queued_q", q_fb, 0);
    chk("queued_queue", sb.size(), 0);

    // Q_FB stuck at 0: FAULT after the set's CHECK and sticky until RST.
    q_tie0 = 1'b1;
    @(negedge CLK);
    k = cyc; set_in = 1'b1; push(1'b1, k + LAT);
    fault_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 10) set_in = 1'b0;
      if (fault && fault_at < 0) fault_at = cyc;
    end
    chk("fault_at", fault_at, k + LAT + 4);
    cmd(1'b0);
    chk("fault_sticky_1", fault, 1);
    cmd(1'b1);
    chk("fault_sticky_2", fault, 1);
    cmd(1'b0);
    chk("fault_sticky_3", fault, 1);
    @(negedge CLK);
    rst = 1'b1;
    #1;
    chk("fault_cleared_async", fault, 0);
    @(negedge CLK);
    rst = 1'b0;
    q_tie0 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("fault_after_release", fault, 0);

    // PULSE_LEN=3 instance: async reset in the second pulse cycle.
    @(negedge CLK);
    k = cyc; set3 = 1'b1;
    repeat (10) @(negedge CLK);
    chk("s3_mid_pulse", s3, 1);
    set3 = 1'b0;
    #2 rst3 = 1'b1;
    #1;
    chk("s3_async_drop", s3, 0);
    chk("busy3_in_reset", busy3, 0);
    repeat (2) @(negedge CLK);
    rst3 = 1'b0;
    s3_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      s3_n += int'(s3);
    end
    chk("s3_quiet_after_reset", s3_n, 0);
    @(negedge CLK);
    k = cyc; set3 = 1'b1;
    s3_first = -1; s3_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 10) set3 = 1'b0;
      if (s3) begin
        if (s3_first < 0) s3_first = cyc;
        s3_n++;
      end
    end
    chk("s3_fresh_start", s3_first, k + LAT);
    chk("s3_fresh_width", s3_n, 3);
    chk("s3_fault", fault3, 0);

    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
